// File: rtl/nibble_serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type, nibble width and counter sizing for nibble_serial_adder
package serial_adder_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int NIBBLE_W = 4;
   function automatic int count_w(input int nibbles);
      return $clog2(nibbles + 1);
   endfunction
endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder; a,b,ci in -> s,co out
module cla4_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [3:0] g, p;
   logic [4:0] c;
   assign g = a & b;
   assign p = a ^ b;
   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & ci);
   assign s = p ^ c[3:0];
   assign co = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder run one nibble per clock through a single CLA slice; ports clk, rst, in_valid/in_ready/a/b/cin[/sub], out_valid/out_ready/sum/cout/ovf; SERIAL_ADDER_SUB_EN adds the sub port
module nibble_serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int CW = count_w(NIBBLES);
   if (WIDTH < NIBBLE_W || WIDTH % NIBBLE_W != 0) begin : g_width_chk
      $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
   end
   state_t state;
   logic [CW-1:0] count;
   logic carry, a_msb, b_msb;
   logic [WIDTH-1:0] a_sh, b_sh, b_eff;
   logic carry_init;
   logic [NIBBLE_W-1:0] s;
   logic co;
   logic [WIDTH+NIBBLE_W-1:0] sum_next;
`ifdef SERIAL_ADDER_SUB_EN
   // subtraction is A + ~B + 1, so the incoming cin is overridden
   assign b_eff = sub ? ~b : b;
   assign carry_init = sub | cin;
`else
   assign b_eff = b;
   assign carry_init = cin;
`endif
   cla4_slice u_slice (
      .a  (a_sh[NIBBLE_W-1:0]),
      .b  (b_sh[NIBBLE_W-1:0]),
      .ci (carry),
      .s  (s),
      .co (co)
   );
   // new nibble enters at the MSB end; after NIBBLES shifts it lands in place
   assign sum_next = {s, sum};
   assign in_ready = state == IDLE;
   assign out_valid = state == DONE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         carry <= 1'b0;
         sum <= '0;
         cout <= 1'b0;
         ovf <= 1'b0;
         a_sh <= '0;
         b_sh <= '0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               state <= RUN;
               a_sh <= a;
               b_sh <= b_eff;
               carry <= carry_init;
               count <= '0;
               a_msb <= a[WIDTH-1];
               b_msb <= b_eff[WIDTH-1];
            end
            RUN: begin
               sum <= sum_next[WIDTH+NIBBLE_W-1:NIBBLE_W];
               a_sh <= a_sh >> NIBBLE_W;
               b_sh <= b_sh >> NIBBLE_W;
               carry <= co;
               count <= count + 1'b1;
               if (count == CW'(NIBBLES - 1)) begin
                  state <= DONE;
                  cout <= co;
                  ovf <= (a_msb == b_msb) && (s[NIBBLE_W-1] != a_msb);
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
